// File: rtl/mem_stage_lsu.sv
// MEMORY stage load/store unit: drives a single-port active-low SRAM with
// byte write masks, stalls the pipeline while a load is in flight, flags
// misaligned/illegal accesses and registers the retired result towards WB.
module mem_stage_lsu #(
    parameter int MEM_ADDR_SIZE = 10,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     EN,
    input  logic                     START,
    input  logic                     MEM_in_valid,
    input  logic [31:0]              MEM_in_instr,
    input  logic [31:0]              MEM_in_ALU_res,
    input  logic                     MEM_in_MemRead,
    input  logic                     MEM_in_MemWrite,
    input  logic [2:0]               MEM_in_funct3,
    input  logic [31:0]              MEM_in_reg_data_2,
    output logic                     MEM_csb0,
    output logic                     MEM_web0,
    output logic [3:0]               MEM_wmask0,
    output logic [MEM_ADDR_SIZE-1:0] MEM_addr0,
    output logic [31:0]              MEM_din0,
    input  logic [31:0]              MEM_dout0,
    output logic                     MEM_stall,
    output logic                     WB_out_valid,
    output logic [31:0]              WB_out_instr,
    output logic [31:0]              WB_out_data,
    output logic                     WB_out_fault
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    logic [1:0]  state_reg;
    logic [1:0]  cnt_reg;
    logic [31:0] buf_reg;
    logic [31:0] instr_reg;
    logic [1:0]  off_reg;
    logic [2:0]  f3_reg;

    logic        enabled;
    logic [1:0]  off;
    logic        is_mem;
    logic        legal_f3;
    logic        misaligned;
    logic        fault;
    logic        issue;
    logic        issue_load;
    logic        issue_store;
    logic        wait_done;
    logic        retire_now;
    logic        retire_load;
    logic [31:0] load_word;
    logic [3:0]  store_mask;
    logic [31:0] store_data;

    // Lane-select and extend a captured SRAM word for the given load type.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  o,
                                                input logic [2:0]  f);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign enabled = EN & START;
    assign off     = MEM_in_ALU_res[1:0];
    assign is_mem  = MEM_in_MemRead | MEM_in_MemWrite;

    // Decode access legality and the store lane pattern from the stage inputs.
    always_comb begin
        legal_f3 = 1'b0;
        if (MEM_in_MemWrite) begin
            legal_f3 = (MEM_in_funct3 == 3'd0) || (MEM_in_funct3 == 3'd1) ||
                       (MEM_in_funct3 == 3'd2);
        end else if (MEM_in_MemRead) begin
            legal_f3 = (MEM_in_funct3 == 3'd0) || (MEM_in_funct3 == 3'd1) ||
                       (MEM_in_funct3 == 3'd2) || (MEM_in_funct3 == 3'd4) ||
                       (MEM_in_funct3 == 3'd5);
        end
        misaligned = ((MEM_in_funct3[1:0] == 2'b01) && off[0]) ||
                     ((MEM_in_funct3[1:0] == 2'b10) && (off != 2'd0));
        case (MEM_in_funct3[1:0])
            2'b00: begin
                store_mask = 4'b0001 << off;
                store_data = {4{MEM_in_reg_data_2[7:0]}};
            end
            2'b01: begin
                store_mask = 4'b0011 << off;
                store_data = {2{MEM_in_reg_data_2[15:0]}};
            end
            default: begin
                store_mask = 4'b1111;
                store_data = MEM_in_reg_data_2;
            end
        endcase
    end

    assign fault = MEM_in_valid && is_mem &&
                   ((MEM_in_MemRead && MEM_in_MemWrite) || !legal_f3 || misaligned);

    assign issue       = (state_reg == ST_IDLE) && enabled && MEM_in_valid && is_mem && !fault;
    assign issue_load  = issue && MEM_in_MemRead;
    assign issue_store = issue && MEM_in_MemWrite;
    assign wait_done   = (state_reg == ST_WAIT) && (cnt_reg == 2'd0);
    assign retire_load = (wait_done || (state_reg == ST_DONE)) && enabled;
    assign retire_now  = (state_reg == ST_IDLE) && enabled && MEM_in_valid && !issue_load;
    assign load_word   = load_extend(MEM_dout0, off_reg, f3_reg);

    // SRAM strobes and stall; everything is forced quiet while in reset.
    always_comb begin
        MEM_csb0   = 1'b1;
        MEM_web0   = 1'b1;
        MEM_wmask0 = 4'b0000;
        MEM_addr0  = '0;
        MEM_din0   = 32'd0;
        MEM_stall  = 1'b0;
        if (RSTn) begin
            MEM_addr0  = MEM_in_ALU_res[MEM_ADDR_SIZE+1:2];
            MEM_din0   = store_data;
            MEM_csb0   = !issue;
            MEM_web0   = !issue_store;
            MEM_wmask0 = issue_store ? store_mask : 4'b0000;
            MEM_stall  = issue_load ||
                         (((state_reg == ST_WAIT) || (state_reg == ST_DONE)) && !retire_load);
        end
    end

    // Load sequencer: latch the load at issue, count latency, buffer the word.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            buf_reg   <= 32'd0;
            instr_reg <= 32'd0;
            off_reg   <= 2'd0;
            f3_reg    <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue_load) begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= CNT_INIT;
                        instr_reg <= MEM_in_instr;
                        off_reg   <= off;
                        f3_reg    <= MEM_in_funct3;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 2'd0) begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end else begin
                        buf_reg   <= load_word;
                        state_reg <= enabled ? ST_IDLE : ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (enabled) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // WB register: update only on enabled cycles, hold otherwise.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            WB_out_valid <= 1'b0;
            WB_out_instr <= 32'd0;
            WB_out_data  <= 32'd0;
            WB_out_fault <= 1'b0;
        end else if (enabled) begin
            if (retire_now) begin
                WB_out_valid <= 1'b1;
                WB_out_instr <= MEM_in_instr;
                WB_out_data  <= (fault || MEM_in_MemWrite) ? 32'd0 : MEM_in_ALU_res;
                WB_out_fault <= fault;
            end else if (retire_load) begin
                WB_out_valid <= 1'b1;
                WB_out_instr <= instr_reg;
                WB_out_data  <= (state_reg == ST_WAIT) ? load_word : buf_reg;
                WB_out_fault <= 1'b0;
            end else begin
                WB_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: behavioural SRAM with read latency, a vector table
// of loads/stores/faults, a WB scoreboard, and hand-written stall/reset cases.
module tb_mem_stage_lsu;

    localparam int AW  = 10;
    localparam int LAT = 3;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          EN;
    logic          START;
    logic          MEM_in_valid;
    logic [31:0]   MEM_in_instr;
    logic [31:0]   MEM_in_ALU_res;
    logic          MEM_in_MemRead;
    logic          MEM_in_MemWrite;
    logic [2:0]    MEM_in_funct3;
    logic [31:0]   MEM_in_reg_data_2;
    logic          MEM_csb0;
    logic          MEM_web0;
    logic [3:0]    MEM_wmask0;
    logic [AW-1:0] MEM_addr0;
    logic [31:0]   MEM_din0;
    logic [31:0]   MEM_dout0;
    logic          MEM_stall;
    logic          WB_out_valid;
    logic [31:0]   WB_out_instr;
    logic [31:0]   WB_out_data;
    logic          WB_out_fault;

    always #5 CLK = ~CLK;

    mem_stage_lsu #(.MEM_ADDR_SIZE(AW), .MEM_LATENCY(LAT)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .START(START),
        .MEM_in_valid(MEM_in_valid), .MEM_in_instr(MEM_in_instr),
        .MEM_in_ALU_res(MEM_in_ALU_res), .MEM_in_MemRead(MEM_in_MemRead),
        .MEM_in_MemWrite(MEM_in_MemWrite), .MEM_in_funct3(MEM_in_funct3),
        .MEM_in_reg_data_2(MEM_in_reg_data_2),
        .MEM_csb0(MEM_csb0), .MEM_web0(MEM_web0), .MEM_wmask0(MEM_wmask0),
        .MEM_addr0(MEM_addr0), .MEM_din0(MEM_din0), .MEM_dout0(MEM_dout0),
        .MEM_stall(MEM_stall),
        .WB_out_valid(WB_out_valid), .WB_out_instr(WB_out_instr),
        .WB_out_data(WB_out_data), .WB_out_fault(WB_out_fault)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // SRAM model: masked writes at the edge, read data valid exactly LAT cycles
    // after the issue cycle and garbage otherwise.
    logic [31:0]   sram [0:(1<<AW)-1] = '{default: 32'h0};
    logic          rd_vld_pipe  [0:LAT-1] = '{default: 1'b0};
    logic [AW-1:0] rd_addr_pipe [0:LAT-1] = '{default: '0};

    always @(posedge CLK) begin
        if (!RSTn) sram[10'h038] <= 32'h80FF_7F01;
        if (!MEM_csb0 && !MEM_web0) begin
            for (int i = 0; i < 4; i++)
                if (MEM_wmask0[i]) sram[MEM_addr0][8*i +: 8] <= MEM_din0[8*i +: 8];
        end
        rd_vld_pipe[0]  <= !MEM_csb0 && MEM_web0;
        rd_addr_pipe[0] <= MEM_addr0;
        for (int i = 1; i < LAT; i++) begin
            rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
            rd_addr_pipe[i] <= rd_addr_pipe[i-1];
        end
    end

    assign MEM_dout0 = rd_vld_pipe[LAT-1] ? sram[rd_addr_pipe[LAT-1]] : 32'hDEAD_BEEF;

    // WB scoreboard: one record per expected retirement.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
        logic        fault;
    } wb_t;
    wb_t sb_q [$];

    always @(posedge CLK) begin
        logic en_s;
        logic rst_s;
        wb_t  e;
        en_s  = EN & START;
        rst_s = RSTn;
        #1;
        if (rst_s && en_s && WB_out_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected_valid", {31'd0, WB_out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_instr", WB_out_instr, e.instr);
                chk("wb_data", WB_out_data, e.data);
                chk("wb_fault", {31'd0, WB_out_fault}, {31'd0, e.fault});
                $display("retire instr=%h data=%h fault=%0d", WB_out_instr, WB_out_data, WB_out_fault);
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] instr;
        logic        exp_csb;
        logic        exp_web;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_din;
        logic        exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] instr, input logic csb, input logic web,
                                input logic [3:0] wm, input logic [31:0] din,
                                input logic flt, input logic [31:0] data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.instr = instr;
        v.exp_csb = csb; v.exp_web = web; v.exp_wmask = wm; v.exp_din = din;
        v.exp_fault = flt; v.exp_data = data;
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] instr);
        MEM_in_valid      = 1'b1;
        MEM_in_MemRead    = rd;
        MEM_in_MemWrite   = wr;
        MEM_in_funct3     = f3;
        MEM_in_ALU_res    = addr;
        MEM_in_reg_data_2 = rs2;
        MEM_in_instr      = instr;
    endtask

    task automatic drive_idle();
        MEM_in_valid    = 1'b0;
        MEM_in_MemRead  = 1'b0;
        MEM_in_MemWrite = 1'b0;
    endtask

    // Apply one vector in the cycle after the previous retire and follow a load
    // through its stall window.
    task automatic run_vec(input vec_t v);
        int  stall_cnt;
        logic is_load;
        is_load = v.rd && !v.exp_fault;
        @(negedge CLK);
        drive(v.rd, v.wr, v.f3, v.addr, v.rs2, v.instr);
        #1;
        $display("issue instr=%h rd=%0d wr=%0d f3=%0d addr=%h csb0=%0d web0=%0d wmask=%b din=%h",
                 v.instr, v.rd, v.wr, v.f3, v.addr, MEM_csb0, MEM_web0, MEM_wmask0, MEM_din0);
        chk("csb0", {31'd0, MEM_csb0}, {31'd0, v.exp_csb});
        chk("web0", {31'd0, MEM_web0}, {31'd0, v.exp_web});
        chk("wmask0", {28'd0, MEM_wmask0}, {28'd0, v.exp_wmask});
        chk("stall_issue", {31'd0, MEM_stall}, {31'd0, is_load});
        if (!v.exp_csb) chk("addr0", {22'd0, MEM_addr0}, {22'd0, v.addr[AW+1:2]});
        if (v.wr && !v.exp_fault) chk("din0", MEM_din0, v.exp_din);
        sb_q.push_back('{instr: v.instr, data: v.exp_data, fault: v.exp_fault});
        @(posedge CLK);
        if (is_load) begin
            stall_cnt = 1;
            for (int c = 0; c < 20; c++) begin
                @(negedge CLK);
                if (!MEM_stall) break;
                stall_cnt++;
                chk("csb0_wait", {31'd0, MEM_csb0}, 32'd1);
                @(posedge CLK);
            end
            chk("stall_cycles", stall_cnt, LAT);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_csb0", {31'd0, MEM_csb0}, 32'd1);
        chk("rst_web0", {31'd0, MEM_web0}, 32'd1);
        chk("rst_wmask0", {28'd0, MEM_wmask0}, 32'd0);
        chk("rst_addr0", {22'd0, MEM_addr0}, 32'd0);
        chk("rst_din0", MEM_din0, 32'd0);
        chk("rst_stall", {31'd0, MEM_stall}, 32'd0);
        chk("rst_wb_valid", {31'd0, WB_out_valid}, 32'd0);
        chk("rst_wb_instr", WB_out_instr, 32'd0);
        chk("rst_wb_data", WB_out_data, 32'd0);
        chk("rst_wb_fault", {31'd0, WB_out_fault}, 32'd0);
    endtask

    initial begin
        //              rd    wr    f3    addr         rs2           instr         csb  web  wmask    din           flt  data
        vecs[0]  = mk(1'b0, 1'b1, 3'd0, 32'h0000_0039, 32'h1234_56AB, 32'h1000_0000, 1'b0, 1'b0, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b1, 3'd1, 32'h0000_003A, 32'h0000_CAFE, 32'h1000_0001, 1'b0, 1'b0, 4'b1100, 32'hCAFE_CAFE, 1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 3'd2, 32'h0000_003C, 32'h1122_3344, 32'h1000_0002, 1'b0, 1'b0, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 3'd2, 32'h0000_0038, 32'h0,         32'h1000_0003, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hCAFE_AB00);
        vecs[4]  = mk(1'b1, 1'b0, 3'd0, 32'h0000_00E3, 32'h0,         32'h1000_0004, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_FF80);
        vecs[5]  = mk(1'b1, 1'b0, 3'd4, 32'h0000_00E3, 32'h0,         32'h1000_0005, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_0080);
        vecs[6]  = mk(1'b1, 1'b0, 3'd1, 32'h0000_00E2, 32'h0,         32'h1000_0006, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_80FF);
        vecs[7]  = mk(1'b1, 1'b0, 3'd5, 32'h0000_00E2, 32'h0,         32'h1000_0007, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_80FF);
        vecs[8]  = mk(1'b1, 1'b0, 3'd0, 32'h0000_00E1, 32'h0,         32'h1000_0008, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_007F);
        vecs[9]  = mk(1'b1, 1'b0, 3'd1, 32'h0000_003E, 32'h0,         32'h1000_0009, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_1122);
        vecs[10] = mk(1'b1, 1'b0, 3'd4, 32'h0000_003C, 32'h0,         32'h1000_000A, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_0044);
        vecs[11] = mk(1'b1, 1'b0, 3'd1, 32'h0000_0041, 32'h0,         32'h1000_000B, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[12] = mk(1'b0, 1'b1, 3'd2, 32'h0000_0042, 32'h5555_5555, 32'h1000_000C, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 3'd3, 32'h0000_0040, 32'h0,         32'h1000_000D, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[14] = mk(1'b1, 1'b1, 3'd2, 32'h0000_0040, 32'h6666_6666, 32'h1000_000E, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[15] = mk(1'b0, 1'b1, 3'd4, 32'h0000_0040, 32'h7777_7777, 32'h1000_000F, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[16] = mk(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0,         32'h1000_0010, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h1234_5678);
        vecs[17] = mk(1'b1, 1'b0, 3'd2, 32'h0000_003A, 32'h0,         32'h1000_0011, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[18] = mk(1'b0, 1'b1, 3'd1, 32'h0000_003D, 32'h8888_8888, 32'h1000_0012, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[19] = mk(1'b1, 1'b0, 3'd6, 32'h0000_0040, 32'h0,         32'h1000_0013, 1'b1, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0);
        vecs[20] = mk(1'b1, 1'b0, 3'd2, 32'h0000_003C, 32'h0,         32'h1000_0014, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h1122_3344);

        // Reset for two edges with random stimulus.
        RSTn  = 1'b0;
        EN    = 1'b1;
        START = 1'b1;
        drive(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
        for (int r = 0; r < 2; r++) begin
            @(negedge CLK);
            #1;
            $display("reset cycle %0d csb0=%0d stall=%0d wb_valid=%0d", r, MEM_csb0, MEM_stall, WB_out_valid);
            check_reset_outputs();
            drive(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
        end
        RSTn = 1'b1;
        drive_idle();

        // Table: stores, lane/sign variants of loads, faults, pass-through.
        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Non-enabled IDLE cycle: a valid store is not issued and WB holds.
        @(negedge CLK);
        START = 1'b0;
        drive(1'b0, 1'b1, 3'd2, 32'h0000_0050, 32'hFFFF_FFFF, 32'h2000_0000);
        #1;
        $display("disabled store csb0=%0d stall=%0d", MEM_csb0, MEM_stall);
        chk("dis_csb0", {31'd0, MEM_csb0}, 32'd1);
        chk("dis_stall", {31'd0, MEM_stall}, 32'd0);
        @(negedge CLK);
        chk("dis_wb_valid_hold", {31'd0, WB_out_valid}, 32'd1);
        chk("dis_wb_instr_hold", WB_out_instr, vecs[NV-1].instr);
        chk("dis_wb_data_hold", WB_out_data, vecs[NV-1].exp_data);
        START = 1'b1;
        drive_idle();
        @(negedge CLK);
        chk("idle_wb_valid_clear", {31'd0, WB_out_valid}, 32'd0);
        run_vec(mk(1'b1, 1'b0, 3'd2, 32'h0000_0050, 32'h0, 32'h2000_0001,
                   1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0));

        // Load, then four non-enabled cycles: result parks in the buffer.
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'd0, 32'h0000_00E3, 32'h0, 32'h3000_0000);
        #1;
        chk("done_issue_csb0", {31'd0, MEM_csb0}, 32'd0);
        chk("done_issue_stall", {31'd0, MEM_stall}, 32'd1);
        sb_q.push_back('{instr: 32'h3000_0000, data: 32'hFFFF_FF80, fault: 1'b0});
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            EN = 1'b0;
            #1;
            $display("hold cycle T+%0d stall=%0d wb_valid=%0d", k, MEM_stall, WB_out_valid);
            chk("done_hold_stall", {31'd0, MEM_stall}, 32'd1);
            chk("done_hold_csb0", {31'd0, MEM_csb0}, 32'd1);
            chk("done_hold_wb_valid", {31'd0, WB_out_valid}, 32'd0);
        end
        @(negedge CLK);
        EN = 1'b1;
        #1;
        chk("done_retire_stall", {31'd0, MEM_stall}, 32'd0);
        @(negedge CLK);
        drive_idle();

        // Reset while a load is in flight: no retirement afterwards.
        @(negedge CLK);
        drive(1'b1, 1'b0, 3'd2, 32'h0000_00E0, 32'h0, 32'h4000_0000);
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, MEM_stall}, 32'd0);
        chk("midrst_csb0", {31'd0, MEM_csb0}, 32'd1);
        @(negedge CLK);
        RSTn = 1'b1;
        drive_idle();
        #1;
        $display("after mid-load reset stall=%0d wb_valid=%0d", MEM_stall, WB_out_valid);
        chk("midrst_after_stall", {31'd0, MEM_stall}, 32'd0);
        chk("midrst_after_wb_valid", {31'd0, WB_out_valid}, 32'd0);
        chk("midrst_after_wb_instr", WB_out_instr, 32'd0);
        repeat (6) @(negedge CLK);
        chk("midrst_idle_stall", {31'd0, MEM_stall}, 32'd0);
        run_vec(mk(1'b1, 1'b0, 3'd2, 32'h0000_00E0, 32'h0, 32'h4000_0001,
                   1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h80FF_7F01));

        @(negedge CLK);
        drive_idle();
        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
